// File: rtl/fifo_sr_pkg.sv
// Shared definitions for the fifo_sr family: default widths, the delivered-word
// counter type and the occupancy type of the default-depth drain buffer.
package fifo_sr_pkg;

  localparam int unsigned W_DEF   = 32;
  localparam int unsigned D_DEF   = 2;
  localparam int unsigned COUNT_W = 32;

  typedef logic [COUNT_W-1:0] count_t;

  localparam int unsigned OCC_W_DEF = $clog2(D_DEF) + 1;
  typedef logic [OCC_W_DEF-1:0] occ_t;

endpackage

// File: rtl/fifo_sr_drain_buf.sv
// D-entry circular buffer feeding the registered output stream of fifo_sr_drain.
// The head word and its valid flag are registered, computed from next state.
module fifo_sr_drain_buf
  import fifo_sr_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned D = D_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [W-1:0]       push_data_i,
  input  logic               take_i,
  input  logic               flush_i,
  output logic               valid_o,
  output logic [W-1:0]       data_o,
  output logic [$clog2(D):0] cnt_o
);

  localparam int unsigned PTR_W = $clog2(D);

  logic [W-1:0]     mem_q [D];
  logic [W-1:0]     mem_d [D];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;

  // Next-state: storage, wrapping pointers, occupancy and the next head word.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (take_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_i, take_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
    valid_d = (cnt_d != '0);
    // An empty buffer keeps the last word visible so out_data never glitches.
    data_d  = valid_d ? mem_d[rd_ptr_d] : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(D); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/fifo_sr_drain.sv
// Read-side master for fifo_sr: pops whenever the output buffer can take a word,
// presents words on a registered valid/ready stream, counts deliveries, flags errors.
module fifo_sr_drain
  import fifo_sr_pkg::*;
#(
  parameter int unsigned W         = W_DEF,
  parameter int unsigned D         = D_DEF,
  parameter count_t      COUNT_RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fifo_empty_r,
  output logic         fifo_pop,
  input  logic [W-1:0] fifo_pop_data,
  input  logic         fifo_pop_data_valid_r,
  input  logic         flush,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output count_t       out_count_r,
  output logic         err_r
);

  localparam int unsigned OCC_W = $clog2(D) + 1;
  typedef logic [OCC_W-1:0] occ_w_t;
  localparam occ_w_t D_OCC = occ_w_t'(D);

  occ_w_t cnt_s;
  logic   xfer_s;
  logic   pop_d1_q, pop_d1_d;
  logic   err_q, err_d;
  count_t count_q, count_d;

  assign xfer_s = out_valid && out_ready;

  // A full buffer may still pop when its head leaves in the same cycle.
  assign fifo_pop = rst_n && !fifo_empty_r && !flush &&
                    ((cnt_s < D_OCC) || xfer_s);

  fifo_sr_drain_buf #(
    .W (W),
    .D (D)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_pop),
    .push_data_i (fifo_pop_data),
    .take_i      (xfer_s),
    .flush_i     (flush),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .cnt_o       (cnt_s)
  );

  always_comb begin
    pop_d1_d = fifo_pop;
    err_d    = err_q | (fifo_pop_data_valid_r != pop_d1_q);
    count_d  = xfer_s ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_d1_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= COUNT_RST;
    end else begin
      pop_d1_q <= pop_d1_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign out_count_r = count_q;
  assign err_r       = err_q;

endmodule

// File: tb/tb_fifo_sr_drain.sv
// Directed bench for fifo_sr_drain with a queue model of the upstream fifo_sr
// and a scoreboard on the output stream.
module tb_fifo_sr_drain;

  localparam int W = 32;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty_r, fifo_pop, fifo_pop_data_valid_r, flush;
  logic        out_valid, out_ready, err_r;
  logic [W-1:0] fifo_pop_data, out_data;
  logic [31:0] out_count_r;
  logic        w_pop, w_valid, w_err;
  logic [W-1:0] w_data;
  logic [31:0] w_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_sr_drain #(.W(W), .D(D)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty_r(fifo_empty_r), .fifo_pop(fifo_pop),
    .fifo_pop_data(fifo_pop_data), .fifo_pop_data_valid_r(fifo_pop_data_valid_r),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_count_r(out_count_r), .err_r(err_r)
  );

  // Identical stimulus; only the counter reset value differs, to reach the wrap.
  fifo_sr_drain #(.W(W), .D(D), .COUNT_RST(32'hFFFF_FFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .fifo_empty_r(fifo_empty_r), .fifo_pop(w_pop),
    .fifo_pop_data(fifo_pop_data), .fifo_pop_data_valid_r(fifo_pop_data_valid_r),
    .flush(flush), .out_valid(w_valid), .out_data(w_data), .out_ready(out_ready),
    .out_count_r(w_count), .err_r(w_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Upstream fifo_sr model
  logic [31:0] fq[$];
  logic        pop_seen = 1'b0;
  logic        pdv_q;
  logic        force_pdv = 1'b0;
  int          pop_total = 0;

  task automatic refresh();
    fifo_empty_r  = (fq.size() == 0);
    fifo_pop_data = (fq.size() == 0) ? 32'h0 : fq[0];
  endtask

  always @(negedge clk) pop_seen = fifo_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pdv_q <= 1'b0;
    else        pdv_q <= pop_seen;
  end

  always @(posedge clk) begin
    if (rst_n && pop_seen) begin
      void'(fq.pop_front());
      pop_total++;
    end
    #1;
    refresh();
  end

  assign fifo_pop_data_valid_r = force_pdv | pdv_q;

  // Scoreboard and never-pop-empty monitor
  logic [31:0] exp_q[$];
  bit          sb_en = 1'b0;
  int          xfers = 0;

  always @(negedge clk) begin
    check("pop_when_empty", {31'b0, fifo_pop & fifo_empty_r}, 32'h0);
    if (sb_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_extra_word", 32'(exp_q.size()), 32'd1);
      else                   check("sb_data", out_data, exp_q.pop_front());
      xfers++;
    end
  end

  task automatic push(input logic [31:0] v);
    fq.push_back(v);
    if (sb_en) exp_q.push_back(v);
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int base;
    flush = 1'b0;
    out_ready = 1'b0;
    fq.push_back(32'h99);
    refresh();
    #12;
    check("rst_pop", {31'b0, fifo_pop}, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_count", out_count_r, 32'h0);
    check("rst_err", {31'b0, err_r}, 32'h0);
    check("rst_wrap_count", w_count, 32'hFFFF_FFFE);
    fq.delete();
    refresh();
    tick();
    rst_n = 1'b1;

    // 1: streaming at one word per cycle
    tick();
    sb_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(32'(i));
    @(negedge clk);
    check("t1_first_pop", {31'b0, fifo_pop}, 32'h1);
    check("t1_no_bypass", {31'b0, out_valid}, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("t1_valid", {31'b0, out_valid}, 32'h1);
      check("t1_data", out_data, 32'(i));
    end
    @(negedge clk);
    check("t1_idle", {31'b0, out_valid}, 32'h0);
    check("t1_count", out_count_r, 32'd8);
    check("t1_xfers", 32'(xfers), 32'd8);
    check("t1_err", {31'b0, err_r}, 32'h0);

    // 2: backpressure stops popping at D words
    tick();
    out_ready = 1'b0;
    base = pop_total;
    push(32'hA); push(32'hB); push(32'hC);
    repeat (4) @(negedge clk);
    check("t2_pops_held", 32'(pop_total - base), 32'd2);
    check("t2_no_pop_full", {31'b0, fifo_pop}, 32'h0);
    check("t2_valid", {31'b0, out_valid}, 32'h1);
    check("t2_head", out_data, 32'hA);
    @(negedge clk);
    check("t2_head_stable", out_data, 32'hA);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_xfer_head", out_data, 32'hA);
    check("t2_pop_with_xfer", {31'b0, fifo_pop}, 32'h1);
    repeat (4) @(negedge clk);
    check("t2_pops_total", 32'(pop_total - base), 32'd3);
    check("t2_xfers", 32'(xfers), 32'd11);
    check("t2_idle", {31'b0, out_valid}, 32'h0);

    // 3: out_ready toggling every cycle
    tick();
    for (int i = 0; i < 16; i++) push(32'h1357_9BDF ^ (32'(i) * 32'h0101_0101));
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      tick();
      out_ready = ~out_ready;
    end
    repeat (3) @(negedge clk);
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check("t3_xfers", 32'(xfers), 32'd27);
    check("t3_fifo_empty", 32'(fq.size()), 32'd0);
    check("t3_count", out_count_r, 32'd27);

    // 4: flush of a full buffer
    tick();
    sb_en = 1'b0;
    out_ready = 1'b0;
    base = pop_total;
    push(32'h5); push(32'h6); push(32'h7);
    repeat (4) @(negedge clk);
    check("t4_full_head", out_data, 32'h5);
    check("t4_full_pops", 32'(pop_total - base), 32'd2);
    tick();
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_no_pop_flush", {31'b0, fifo_pop}, 32'h0);
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("t4_flushed_valid", {31'b0, out_valid}, 32'h0);
    check("t4_flush_xfer_count", out_count_r, 32'd28);
    check("t4_pop_after", {31'b0, fifo_pop}, 32'h1);
    @(negedge clk);
    check("t4_next_valid", {31'b0, out_valid}, 32'h1);
    check("t4_next_word", out_data, 32'h7);
    tick();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_drain_count", out_count_r, 32'd29);
    check("t4_pops", 32'(pop_total - base), 32'd3);

    // 5: protocol error, then reset mid-stream
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("t5_err_clear", {31'b0, err_r}, 32'h0);
    tick();
    force_pdv = 1'b1;
    tick();
    force_pdv = 1'b0;
    @(negedge clk);
    check("t5_err_set", {31'b0, err_r}, 32'h1);
    push(32'h11); push(32'h22);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", {31'b0, err_r}, 32'h1);
    check("t5_streaming", {31'b0, out_valid}, 32'h1);
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'b0, out_valid}, 32'h0);
    check("t5_rst_data", out_data, 32'h0);
    check("t5_rst_err", {31'b0, err_r}, 32'h0);
    check("t5_rst_count", out_count_r, 32'h0);
    check("t5_rst_pop", {31'b0, fifo_pop}, 32'h0);
    fq.delete();
    refresh();
    tick();
    rst_n = 1'b1;

    // 6: delivered-word counter wrap
    tick();
    sb_en = 1'b1;
    out_ready = 1'b1;
    push(32'hAAAA_0001); push(32'hAAAA_0002);
    repeat (2) @(negedge clk);
    check("t6_wrap_start", w_count, 32'hFFFF_FFFE);
    @(negedge clk);
    check("t6_wrap_max", w_count, 32'hFFFF_FFFF);
    @(negedge clk);
    check("t6_wrap_zero", w_count, 32'h0000_0000);
    check("t6_count", out_count_r, 32'd2);
    check("t6_wrap_err", {31'b0, w_err}, 32'h0);
    check("t6_wrap_valid", {31'b0, w_valid}, {31'b0, out_valid});
    check("t6_wrap_data", w_data, 32'hAAAA_0002);
    check("t6_wrap_pop", {31'b0, w_pop}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
